// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the pe context sequencer.
// State encodings, word widths and the null context.
package pe_seq_pkg;

   localparam int CFG_W  = 7;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [CFG_W-1:0] CFG_NOP = '0;

endpackage

// File: rtl/pe_seq_ctx_mem.sv
// Context register file for the pe sequencer.
// Synchronous write, asynchronous read, contents not reset.
module pe_seq_ctx_mem
   import pe_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [CFG_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [CFG_W-1:0] rdata
);

   logic [CFG_W-1:0] mem [DEPTH];

   // store one context word per accepted write
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Per-tile context sequencer: streams stored contexts to one pe.
// Optional PE_SEQ_LOOP_EN adds loop_cnt for back-to-back repeat passes.
module pe_ctx_sequencer
   import pe_seq_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int PE_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [CFG_W-1:0]  cfg_wdata,
   input  logic              start,
   input  logic [AW:0]       prog_len,
`ifdef PE_SEQ_LOOP_EN
   input  logic [7:0]        loop_cnt,
`endif
   input  logic [DATA_W-1:0] pe_out,
   output logic [CFG_W-1:0]  pex_config,
   output logic              ctx_valid,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(PE_LAT + 1) + 1;

   state_t            state;
   state_t            state_nx;
   logic [AW-1:0]     pc;
   logic [AW-1:0]     last_pc;
   logic [CW-1:0]     cnt;
   logic [CFG_W-1:0]  rd;
   logic [PE_LAT-1:0] vld_sh;
   logic [PE_LAT:0]   vld_nx;
   logic              idle;
   logic              bad;
   logic              go;
   logic              wr_ok;
   logic              pass_end;
   logic              more;
   logic              last_issue;
   logic              drain_end;
   logic              hit;
   logic [CFG_W-1:0]  cfg_nx;
   logic              cv_nx;
   logic              busy_nx;
   logic              done_nx;
   logic              err_nx;

   // idle also excludes the done cycle, when state is already IDLE
   assign idle   = (state == IDLE) && !busy;
   assign bad    = (prog_len == '0) ||
                   (prog_len > (AW+1)'(DEPTH));
   assign go     = idle && start && !bad;
   assign wr_ok  = cfg_we && idle;

   assign pass_end   = (state == RUN) && (pc == last_pc);
   assign last_issue = pass_end && !more;
   assign drain_end  = (state == DRAIN) && (cnt == '0);

   assign vld_nx = {vld_sh, ctx_valid};
   assign hit    = vld_sh[PE_LAT-1];

`ifdef PE_SEQ_LOOP_EN
   logic [7:0] loops;

   assign more = (loops != 8'd0);

   // remaining repeat passes after the current one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         loops <= 8'd0;
      end else if (go) begin
         loops <= loop_cnt;
      end else if (pass_end && more) begin
         loops <= loops - 8'd1;
      end
   end
`else
   assign more = 1'b0;
`endif

   pe_seq_ctx_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (pc),
      .rdata (rd)
   );

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (go)         state_nx = RUN;
         RUN:     if (last_issue) state_nx = DRAIN;
         DRAIN:   if (drain_end)  state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // next values of the registered outputs
   always_comb begin
      cfg_nx  = CFG_NOP;
      cv_nx   = 1'b0;
      if (state == RUN) begin
         cfg_nx = rd;
         cv_nx  = 1'b1;
      end
      busy_nx = (state != IDLE);
      done_nx = drain_end;
      err_nx  = err | (cfg_we && !idle) |
                (start && idle && bad);
   end

   // output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pex_config <= CFG_NOP;
         ctx_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         pex_config <= cfg_nx;
         ctx_valid  <= cv_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         err        <= err_nx;
      end
   end

   // program counter, last index and drain countdown
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= '0;
         last_pc <= '0;
         cnt     <= '0;
      end else begin
         if (go) begin
            pc      <= '0;
            last_pc <= AW'(prog_len - (AW+1)'(1));
         end else if (pass_end) begin
            pc <= '0;
         end else if (state == RUN) begin
            pc <= pc + AW'(1);
         end
         if (last_issue) begin
            cnt <= CW'(PE_LAT);
         end else if ((state == DRAIN) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // realign pe_out with the context that produced it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_sh    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         vld_sh    <= vld_nx[PE_LAT-1:0];
         res_valid <= hit;
         if (hit) res_data <= pe_out;
      end
   end

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed bench for pe_ctx_sequencer with a one-cycle echo pe stub.
// Define PE_SEQ_LOOP_EN to also exercise repeat passes.
module tb_pe_ctx_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [6:0]  cfg_wdata;
   logic        start;
   logic [4:0]  prog_len;
   logic [15:0] pe_out;
   logic [6:0]  pex_config;
   logic        ctx_valid;
   logic        res_valid;
   logic [15:0] res_data;
   logic        busy;
   logic        done;
   logic        err;
`ifdef PE_SEQ_LOOP_EN
   logic [7:0]  loop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic [15:0] pe_q = '0;
   always @(posedge clk) pe_q <= {9'd0, pex_config};
   assign pe_out = pe_q;

   pe_ctx_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .start      (start),
      .prog_len   (prog_len),
`ifdef PE_SEQ_LOOP_EN
      .loop_cnt   (loop_cnt),
`endif
      .pe_out     (pe_out),
      .pex_config (pex_config),
      .ctx_valid  (ctx_valid),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   typedef struct {
      logic        st;
      logic [4:0]  len;
      logic        we;
      logic [3:0]  wa;
      logic [6:0]  wd;
      logic [6:0]  cfg;
      logic        cv;
      logic        rv;
      logic [15:0] rd;
      logic        bsy;
      logic        dn;
      logic        er;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(
      input logic st, input logic [4:0] len,
      input logic we, input logic [6:0] wd,
      input logic [6:0] cfg, input logic cv,
      input logic rv, input logic [15:0] rd,
      input logic bsy, input logic dn, input logic er);
      vec_t v;
      v.st = st; v.len = len; v.we = we;
      v.wa = 4'd0; v.wd = wd;
      v.cfg = cfg; v.cv = cv; v.rv = rv;
      v.rd = rd; v.bsy = bsy; v.dn = dn;
      v.er = er;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      start = 1'b0; prog_len = '0;
   endtask

   task automatic load(input int a, input logic [6:0] d);
      cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         start = tbl[i].st; prog_len = tbl[i].len;
         cfg_we = tbl[i].we; cfg_addr = tbl[i].wa;
         cfg_wdata = tbl[i].wd;
         tick();
         idle_in();
         chk($sformatf("r%0d cfg", i), 32'(pex_config), 32'(tbl[i].cfg));
         chk($sformatf("r%0d cv", i), 32'(ctx_valid), 32'(tbl[i].cv));
         chk($sformatf("r%0d rv", i), 32'(res_valid), 32'(tbl[i].rv));
         chk($sformatf("r%0d rd", i), 32'(res_data), 32'(tbl[i].rd));
         chk($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
         chk($sformatf("r%0d done", i), 32'(done), 32'(tbl[i].dn));
         chk($sformatf("r%0d err", i), 32'(err), 32'(tbl[i].er));
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " cfg"}, 32'(pex_config), 32'd0);
      chk({nm, " cv"}, 32'(ctx_valid), 32'd0);
      chk({nm, " rv"}, 32'(res_valid), 32'd0);
      chk({nm, " rd"}, 32'(res_data), 32'd0);
      chk({nm, " busy"}, 32'(busy), 32'd0);
      chk({nm, " done"}, 32'(done), 32'd0);
      chk({nm, " err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      // single pass, len 2
      tbl[0]  = mk(1, 2, 0, 0, 7'h00, 0, 0, 16'h00, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 7'h12, 1, 0, 16'h00, 1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 7'h1D, 1, 0, 16'h00, 1, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 7'h00, 0, 1, 16'h12, 1, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 7'h00, 0, 1, 16'h1D, 1, 1, 0);
      tbl[5]  = mk(0, 0, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 0);
      // invalid starts
      tbl[6]  = mk(1, 0, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);
      tbl[7]  = mk(1, 17, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);
      tbl[8]  = mk(0, 0, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);
      // write and restart while busy
      tbl[9]  = mk(1, 2, 0, 0, 7'h00, 0, 0, 16'h00, 0, 0, 0);
      tbl[10] = mk(0, 0, 1, 7'h7F, 7'h12, 1, 0, 16'h00, 1, 0, 1);
      tbl[11] = mk(1, 2, 0, 0, 7'h1D, 1, 0, 16'h00, 1, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 7'h00, 0, 1, 16'h12, 1, 0, 1);
      tbl[13] = mk(0, 0, 0, 0, 7'h00, 0, 1, 16'h1D, 1, 1, 1);
      tbl[14] = mk(0, 0, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);
      tbl[15] = mk(0, 0, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);
      // rerun: mem[0] must still be 0x12
      tbl[16] = mk(1, 2, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);
      tbl[17] = mk(0, 0, 0, 0, 7'h12, 1, 0, 16'h1D, 1, 0, 1);
      tbl[18] = mk(0, 0, 0, 0, 7'h1D, 1, 0, 16'h1D, 1, 0, 1);
      tbl[19] = mk(0, 0, 0, 0, 7'h00, 0, 1, 16'h12, 1, 0, 1);
      tbl[20] = mk(0, 0, 0, 0, 7'h00, 0, 1, 16'h1D, 1, 1, 1);
      tbl[21] = mk(0, 0, 0, 0, 7'h00, 0, 0, 16'h1D, 0, 0, 1);

      idle_in();
`ifdef PE_SEQ_LOOP_EN
      loop_cnt = 8'd0;
`endif
      do_reset();
      chk_zero("reset");

      load(0, 7'b0010010);
      load(1, 7'b0011101);
      run_rows(0, 5);
      run_rows(6, 8);
      do_reset();
      chk_zero("rst2");
      run_rows(9, 15);
      run_rows(16, 21);

      // full depth program, mem[i] = i
      for (int i = 0; i < 16; i++) load(i, 7'(i));
      start = 1'b1; prog_len = 5'd16;
      tick();
      idle_in();
      for (int n = 1; n <= 20; n++) begin
         tick();
         chk($sformatf("d16 cv n%0d", n), 32'(ctx_valid),
             32'(n <= 16));
         chk($sformatf("d16 cfg n%0d", n), 32'(pex_config),
             (n <= 16) ? 32'(n - 1) : 32'd0);
         chk($sformatf("d16 rv n%0d", n), 32'(res_valid),
             32'(n >= 3 && n <= 18));
         if (n >= 3 && n <= 18)
            chk($sformatf("d16 rd n%0d", n), 32'(res_data),
                32'(n - 3));
         chk($sformatf("d16 done n%0d", n), 32'(done),
             32'(n == 18));
         chk($sformatf("d16 busy n%0d", n), 32'(busy),
             32'(n <= 18));
      end

      // reset in the cycle after the first issue
      start = 1'b1; prog_len = 5'd4;
      tick();
      idle_in();
      tick();
      chk("mid first cfg", 32'(pex_config), 32'd0);
      chk("mid first cv", 32'(ctx_valid), 32'd1);
      tick();
      reset = 1'b0;
      #1;
      chk_zero("async");
      tick();
      reset = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         chk($sformatf("post rst done %0d", n), 32'(done), 32'd0);
         chk($sformatf("post rst cv %0d", n), 32'(ctx_valid), 32'd0);
      end
      start = 1'b1; prog_len = 5'd2;
      tick();
      idle_in();
      for (int n = 1; n <= 5; n++) begin
         tick();
         chk($sformatf("rerun cv n%0d", n), 32'(ctx_valid),
             32'(n <= 2));
         chk($sformatf("rerun cfg n%0d", n), 32'(pex_config),
             (n <= 2) ? 32'(n - 1) : 32'd0);
         chk($sformatf("rerun rv n%0d", n), 32'(res_valid),
             32'(n == 3 || n == 4));
         if (n == 3 || n == 4)
            chk($sformatf("rerun rd n%0d", n), 32'(res_data),
                32'(n - 3));
         chk($sformatf("rerun done n%0d", n), 32'(done),
             32'(n == 4));
      end

`ifdef PE_SEQ_LOOP_EN
      load(0, 7'h12);
      load(1, 7'h1D);
      start = 1'b1; prog_len = 5'd2; loop_cnt = 8'd2;
      tick();
      idle_in();
      loop_cnt = 8'd0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         chk($sformatf("loop cv n%0d", n), 32'(ctx_valid),
             32'(n <= 6));
         chk($sformatf("loop cfg n%0d", n), 32'(pex_config),
             (n > 6) ? 32'd0 : (n % 2 == 1) ? 32'h12 : 32'h1D);
         chk($sformatf("loop rv n%0d", n), 32'(res_valid),
             32'(n >= 3 && n <= 8));
         if (n >= 3 && n <= 8)
            chk($sformatf("loop rd n%0d", n), 32'(res_data),
                (n % 2 == 1) ? 32'h12 : 32'h1D);
         chk($sformatf("loop done n%0d", n), 32'(done),
             32'(n == 8));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
